// File: rtl/oddrx2_sync_ctrl.sv
// Startup/resync sequencer for the ODDRX2E gearbox and its ECLK path, clocked by SCLK.
// Waits for a settled PLL lock, then runs: stop ECLK, release the gearbox reset while ECLK is stopped, restart ECLK.
module oddrx2_sync_ctrl #(
    parameter int LOCK_CNT  = 16,
    parameter int STOP_CNT  = 4,
    parameter int RST_CNT   = 4,
    parameter int START_CNT = 4
) (
    input  logic SCLK,
    input  logic RST,
    input  logic LOCK,
    input  logic RESYNC,
    output logic STOP,
    output logic DDR_RST,
    output logic READY,
    output logic LOSS,
    output logic BUSY
);

    typedef enum logic [2:0] {
        S_WAITL,
        S_SETTL,
        S_STOPC,
        S_RELS,
        S_STRT,
        S_READY
    } state_t;

    // Each timed state starts its count at N-1 and leaves when the count reaches 0.
    localparam logic [7:0] LD_LOCK  = 8'(LOCK_CNT - 1);
    localparam logic [7:0] LD_STOP  = 8'(STOP_CNT - 1);
    localparam logic [7:0] LD_RST   = 8'(RST_CNT - 1);
    localparam logic [7:0] LD_START = 8'(START_CNT - 1);

    state_t     r_state;
    logic [7:0] r_cnt;
    logic [1:0] r_sync;
    logic       r_stop;
    logic       r_ddr_rst;
    logic       r_ready;
    logic       r_loss;
    logic       r_busy;
    logic       w_lock_s;
    logic       w_cnt_done;

    assign w_lock_s   = r_sync[1];
    assign w_cnt_done = (r_cnt == 8'd0);

    always_ff @(posedge SCLK or posedge RST) begin
        if (RST) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], LOCK};
        end
    end

    always_ff @(posedge SCLK or posedge RST) begin
        if (RST) begin
            r_state   <= S_WAITL;
            r_cnt     <= 8'd0;
            r_stop    <= 1'b0;
            r_ddr_rst <= 1'b1;
            r_ready   <= 1'b0;
            r_loss    <= 1'b0;
            r_busy    <= 1'b0;
        end else if (!w_lock_s && r_state != S_WAITL) begin
            // Lock loss outranks everything else, including a same-cycle RESYNC.
            r_state   <= S_WAITL;
            r_stop    <= 1'b0;
            r_ddr_rst <= 1'b1;
            r_ready   <= 1'b0;
            r_busy    <= 1'b0;
            if (r_state == S_READY) begin
                r_loss <= 1'b1;
            end
        end else begin
            case (r_state)
                S_WAITL: begin
                    if (w_lock_s) begin
                        r_state <= S_SETTL;
                        r_cnt   <= LD_LOCK;
                    end
                end
                S_SETTL: begin
                    if (w_cnt_done) begin
                        r_state <= S_STOPC;
                        r_cnt   <= LD_STOP;
                        r_stop  <= 1'b1;
                        r_busy  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_STOPC: begin
                    if (w_cnt_done) begin
                        r_state   <= S_RELS;
                        r_cnt     <= LD_RST;
                        r_ddr_rst <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_RELS: begin
                    if (w_cnt_done) begin
                        r_state <= S_STRT;
                        r_cnt   <= LD_START;
                        r_stop  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_STRT: begin
                    if (w_cnt_done) begin
                        r_state <= S_READY;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_READY: begin
                    // STOP and DDR_RST rise together so the gearbox never sees a running ECLK in reset release.
                    if (RESYNC) begin
                        r_state   <= S_STOPC;
                        r_cnt     <= LD_STOP;
                        r_stop    <= 1'b1;
                        r_ddr_rst <= 1'b1;
                        r_ready   <= 1'b0;
                        r_busy    <= 1'b1;
                        r_loss    <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= S_WAITL;
                    r_stop    <= 1'b0;
                    r_ddr_rst <= 1'b1;
                    r_ready   <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign STOP    = r_stop;
    assign DDR_RST = r_ddr_rst;
    assign READY   = r_ready;
    assign LOSS    = r_loss;
    assign BUSY    = r_busy;

endmodule

// File: tb/tb_oddrx2_sync_ctrl.sv
// Bench for oddrx2_sync_ctrl: default-parameter instance plus an all-ones instance,
// checked every cycle against a timeline model and at hand-computed edges.
module tb_oddrx2_sync_ctrl;

    localparam int PL [0:1] = '{16, 1};
    localparam int PS [0:1] = '{4, 1};
    localparam int PR [0:1] = '{4, 1};
    localparam int PT [0:1] = '{4, 1};

    logic SCLK = 1'b0;
    logic RST  = 1'b0;
    logic lock0 = 1'b0, resync0 = 1'b0, lock1 = 1'b0, resync1 = 1'b0;
    logic stop0, ddr0, ready0, loss0, busy0;
    logic stop1, ddr1, ready1, loss1, busy1;

    int n_cmp  = 0;
    int n_fail = 0;
    int e      = 0;

    always #5 SCLK = ~SCLK;

    oddrx2_sync_ctrl u_dut0 (
        .SCLK(SCLK), .RST(RST), .LOCK(lock0), .RESYNC(resync0),
        .STOP(stop0), .DDR_RST(ddr0), .READY(ready0), .LOSS(loss0), .BUSY(busy0)
    );

    oddrx2_sync_ctrl #(.LOCK_CNT(1), .STOP_CNT(1), .RST_CNT(1), .START_CNT(1)) u_dut1 (
        .SCLK(SCLK), .RST(RST), .LOCK(lock1), .RESYNC(resync1),
        .STOP(stop1), .DDR_RST(ddr1), .READY(ready1), .LOSS(loss1), .BUSY(busy1)
    );

    // Model: a running sequence is just its start edge t0; the phase follows from elapsed edges.
    typedef struct packed {
        logic act;
        logic loss;
        int   t0;
    } mst_t;

    mst_t       ms [0:1];
    logic [1:0] m_sync0, m_sync1;
    int         m_cyc;

    // 0 WAITL, 1 SETTL, 2 STOPC, 3 RELS, 4 STRT, 5 READY
    function automatic int ph(int i, logic act, int off);
        if (!act) return 0;
        if (off < PL[i]) return 1;
        if (off < PL[i] + PS[i]) return 2;
        if (off < PL[i] + PS[i] + PR[i]) return 3;
        if (off < PL[i] + PS[i] + PR[i] + PT[i]) return 4;
        return 5;
    endfunction

    function automatic mst_t mnext(int i, mst_t s, logic ls, logic rs, int n);
        mst_t r;
        int   cur;
        r   = s;
        cur = ph(i, s.act, n - 1 - s.t0);
        if (!s.act) begin
            if (ls) begin
                r.act = 1'b1;
                r.t0  = n;
            end
        end else if (!ls) begin
            if (cur == 5) r.loss = 1'b1;
            r.act = 1'b0;
        end else if (cur == 5 && rs) begin
            r.t0   = n - PL[i];
            r.loss = 1'b0;
        end
        return r;
    endfunction

    always @(posedge SCLK or posedge RST) begin
        if (RST) begin
            ms[0]   <= '0;
            ms[1]   <= '0;
            m_sync0 <= 2'b00;
            m_sync1 <= 2'b00;
        end else begin
            m_cyc   <= m_cyc + 1;
            ms[0]   <= mnext(0, ms[0], m_sync0[1], resync0, m_cyc + 1);
            ms[1]   <= mnext(1, ms[1], m_sync1[1], resync1, m_cyc + 1);
            m_sync0 <= {m_sync0[0], lock0};
            m_sync1 <= {m_sync1[0], lock1};
        end
    end

    initial m_cyc = 0;

    task automatic chk(string nm, logic act, logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %b, expected %b", nm, e, act, exp);
        end
    endtask

    task automatic check_inst(int i, logic s, logic d, logic r, logic l, logic b);
        int p;
        p = ph(i, ms[i].act, m_cyc - ms[i].t0);
        chk($sformatf("model%0d STOP", i),    s, (p == 2 || p == 3));
        chk($sformatf("model%0d DDR_RST", i), d, (p <= 2));
        chk($sformatf("model%0d READY", i),   r, (p == 5));
        chk($sformatf("model%0d LOSS", i),    l, ms[i].loss);
        chk($sformatf("model%0d BUSY", i),    b, (p >= 2 && p <= 4));
    endtask

    always @(negedge SCLK) begin
        check_inst(0, stop0, ddr0, ready0, loss0, busy0);
        check_inst(1, stop1, ddr1, ready1, loss1, busy1);
    end

    task automatic step();
        @(posedge SCLK);
        e++;
        @(negedge SCLK);
    endtask

    task automatic step_to(int n);
        while (e < n) step();
    endtask

    initial begin
        #1 RST = 1'b1;
        repeat (3) @(negedge SCLK);
        chk("reset STOP", stop0, 1'b0);
        chk("reset DDR_RST", ddr0, 1'b1);
        chk("reset READY", ready0, 1'b0);
        chk("reset LOSS", loss0, 1'b0);
        chk("reset BUSY", busy0, 1'b0);
        RST = 1'b0;
        e   = 0;

        // Startup: LOCK sampled at edge 5
        step_to(4);  lock0 = 1'b1;
        step_to(22); chk("start STOP@22", stop0, 1'b0);
        step_to(23); chk("start STOP@23", stop0, 1'b1); chk("start BUSY@23", busy0, 1'b1);
        step_to(26); chk("start DDR_RST@26", ddr0, 1'b1);
        step_to(27); chk("start DDR_RST@27", ddr0, 1'b0); chk("start STOP@27", stop0, 1'b1);
        step_to(30); chk("start STOP@30", stop0, 1'b1);
        step_to(31); chk("start STOP@31", stop0, 1'b0); chk("start BUSY@31", busy0, 1'b1);
        step_to(34); chk("start READY@34", ready0, 1'b0); chk("start BUSY@34", busy0, 1'b1);
        step_to(35); chk("start READY@35", ready0, 1'b1); chk("start BUSY@35", busy0, 1'b0);

        // RESYNC sampled at edge 41
        step_to(40); resync0 = 1'b1;
        step();      resync0 = 1'b0;
        chk("resync READY@41", ready0, 1'b0); chk("resync STOP@41", stop0, 1'b1);
        chk("resync DDR_RST@41", ddr0, 1'b1);
        step_to(44); chk("resync DDR_RST@44", ddr0, 1'b1);
        step_to(45); chk("resync DDR_RST@45", ddr0, 1'b0); chk("resync STOP@45", stop0, 1'b1);
        step_to(49); chk("resync STOP@49", stop0, 1'b0);
        step_to(52); chk("resync READY@52", ready0, 1'b0);
        step_to(53); chk("resync READY@53", ready0, 1'b1);

        // Lock drop sampled at edge 60, relock sampled at edge 70
        step_to(59); lock0 = 1'b0;
        step_to(61); chk("drop READY@61", ready0, 1'b1); chk("drop LOSS@61", loss0, 1'b0);
        step_to(62); chk("drop READY@62", ready0, 1'b0); chk("drop DDR_RST@62", ddr0, 1'b1);
        chk("drop LOSS@62", loss0, 1'b1);
        step_to(69); lock0 = 1'b1;
        step_to(99);  chk("relock READY@99", ready0, 1'b0); chk("relock LOSS@99", loss0, 1'b1);
        step_to(100); chk("relock READY@100", ready0, 1'b1); chk("relock LOSS@100", loss0, 1'b1);

        // RESYNC clears LOSS
        step_to(104); resync0 = 1'b1;
        step();       resync0 = 1'b0;
        chk("clr LOSS@105", loss0, 1'b0);
        step_to(117); chk("clr READY@117", ready0, 1'b1);

        // Asynchronous RST while in RELS
        step_to(119); resync0 = 1'b1;
        step();       resync0 = 1'b0;
        step_to(125); chk("rels STOP@125", stop0, 1'b1); chk("rels DDR_RST@125", ddr0, 1'b0);
        #2 RST = 1'b1;
        #1;
        chk("arst STOP", stop0, 1'b0); chk("arst DDR_RST", ddr0, 1'b1);
        chk("arst READY", ready0, 1'b0); chk("arst BUSY", busy0, 1'b0);
        step_to(128); RST = 1'b0;
        step_to(158); chk("rst-restart READY@158", ready0, 1'b0);
        step_to(159); chk("rst-restart READY@159", ready0, 1'b1);

        // Glitch during SETTL: relock sampled 173, low sampled 180..182
        step_to(164); lock0 = 1'b0;
        step_to(172); lock0 = 1'b1;
        step_to(179); lock0 = 1'b0;
        step_to(182); lock0 = 1'b1;
        step_to(193); chk("glitch STOP@193", stop0, 1'b0);
        step_to(200); chk("glitch STOP@200", stop0, 1'b0);
        step_to(201); chk("glitch STOP@201", stop0, 1'b1);
        step_to(212); chk("glitch READY@212", ready0, 1'b0);
        step_to(213); chk("glitch READY@213", ready0, 1'b1);

        // All-ones instance: LOCK sampled 220, RESYNC in STRT ignored, coincident loss
        step_to(219); lock1 = 1'b1;
        step_to(223); chk("p1 STOP@223", stop1, 1'b1); chk("p1 DDR_RST@223", ddr1, 1'b1);
        step_to(224); chk("p1 DDR_RST@224", ddr1, 1'b0); chk("p1 STOP@224", stop1, 1'b1);
        step_to(225); chk("p1 STOP@225", stop1, 1'b0); chk("p1 BUSY@225", busy1, 1'b1);
        resync1 = 1'b1;
        step();       resync1 = 1'b0;
        chk("p1 READY@226", ready1, 1'b1); chk("p1 STOP@226", stop1, 1'b0);
        chk("p1 BUSY@226", busy1, 1'b0);
        step_to(229); lock1 = 1'b0;
        step_to(231); chk("p1 READY@231", ready1, 1'b1);
        resync1 = 1'b1;
        step();       resync1 = 1'b0;
        chk("p1 READY@232", ready1, 1'b0); chk("p1 STOP@232", stop1, 1'b0);
        chk("p1 DDR_RST@232", ddr1, 1'b1); chk("p1 LOSS@232", loss1, 1'b1);
        chk("p1 BUSY@232", busy1, 1'b0);

        step_to(240);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
